// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA raster geometry shared by the timing generator and the
// colorizer/icon stages that need visible-area bounds.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    // Inclusive window test on a 10-bit raster coordinate.
    function automatic logic inWindow(logic [9:0] val, logic [9:0] lo, logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that returns to zero after MAX; wrap flags the enabled
// cycle on which that return happens so a following counter can chain off it.
module wrap_counter #(
    parameter int unsigned MAX   = 799,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    assign wrap = en && (count == MAX_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/display_timing_gen.sv
// VGA raster timing: column/row counters stepped by pix_tick, with every output
// registered from the same counter state so they stay mutually aligned.
module display_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_tick,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic       video_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic       hWrap;
    logic       vWrap;

    wrap_counter #(
        .MAX   (H_TOTAL - 1),
        .WIDTH (10)
    ) hCounter (
        .clk   (clk),
        .reset (reset),
        .en    (pix_tick),
        .count (hCnt),
        .wrap  (hWrap)
    );

    // vWrap already implies hWrap, so it marks the full-raster wrap.
    wrap_counter #(
        .MAX   (V_TOTAL - 1),
        .WIDTH (10)
    ) vCounter (
        .clk   (clk),
        .reset (reset),
        .en    (hWrap),
        .count (vCnt),
        .wrap  (vWrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_column <= '0;
            pixel_row    <= '0;
            video_on     <= 1'b0;
            horiz_sync   <= ~SYNC_ACTIVE;
            vert_sync    <= ~SYNC_ACTIVE;
            line_tick    <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            line_tick  <= hWrap;
            frame_tick <= vWrap;
            if (pix_tick) begin
                pixel_column <= hCnt;
                pixel_row    <= vCnt;
                video_on     <= (hCnt < H_VIS) && (vCnt < V_VIS);
                horiz_sync   <= inWindow(hCnt, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vert_sync    <= inWindow(vCnt, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a default 640x480 instance plus a tiny-geometry
// instance (15x10 raster) so full-frame behaviour fits in a short run.
module tb_display_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pix_tick = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] aCol, aRow, bCol, bRow;
    logic aVon, aHs, aVs, aLt, aFt;
    logic bVon, bHs, bVs, bLt, bFt;

    display_timing_gen dutA (
        .clk(clk), .reset(reset), .pix_tick(pix_tick),
        .pixel_column(aCol), .pixel_row(aRow), .video_on(aVon),
        .horiz_sync(aHs), .vert_sync(aVs), .line_tick(aLt), .frame_tick(aFt)
    );

    display_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) dutB (
        .clk(clk), .reset(reset), .pix_tick(pix_tick),
        .pixel_column(bCol), .pixel_row(bRow), .video_on(bVon),
        .horiz_sync(bHs), .vert_sync(bVs), .line_tick(bLt), .frame_tick(bFt)
    );

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       von;
        logic       hs;
        logic       vs;
        logic       lt;
        logic       ft;
    } outs_t;

    localparam outs_t RESET_OUTS = '{col: 10'd0, row: 10'd0, von: 1'b0, hs: 1'b1, vs: 1'b1,
                                     lt: 1'b0, ft: 1'b0};

    int checks = 0;
    int errors = 0;

    // Pixel ticks accepted since reset, and whether the last clk edge carried one.
    longint nTicks = 0;
    bit     lastTick = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            nTicks   <= 0;
            lastTick <= 1'b0;
        end else begin
            lastTick <= pix_tick;
            if (pix_tick) nTicks <= nTicks + 1;
        end
    end

    // The n-th tick after reset presents raster position n-1 in row-major order.
    function automatic outs_t model(input longint n, input bit lt,
                                    input longint ha, input longint hf, input longint hsw,
                                    input longint hb, input longint va, input longint vf,
                                    input longint vsw, input longint vb);
        outs_t  o;
        longint ht, vt, p, c, r;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        o = RESET_OUTS;
        if (n > 0) begin
            p = n - 1;
            c = p % ht;
            r = (p / ht) % vt;
            o.col = 10'(c);
            o.row = 10'(r);
            o.von = (c < ha) && (r < va);
            o.hs  = !((c >= ha + hf) && (c < ha + hf + hsw));
            o.vs  = !((r >= va + vf) && (r < va + vf + vsw));
            o.lt  = lt && (c == ht - 1);
            o.ft  = lt && (c == ht - 1) && (r == vt - 1);
        end
        return o;
    endfunction

    task automatic report(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t actA();
        return '{col: aCol, row: aRow, von: aVon, hs: aHs, vs: aVs, lt: aLt, ft: aFt};
    endfunction

    function automatic outs_t actB();
        return '{col: bCol, row: bRow, von: bVon, hs: bHs, vs: bVs, lt: bLt, ft: bFt};
    endfunction

    always @(negedge clk) begin
        report("dutA vs model", 64'(actA()),
               64'(model(nTicks, lastTick, 640, 16, 96, 48, 480, 10, 2, 33)));
        report("dutB vs model", 64'(actB()),
               64'(model(nTicks, lastTick, 8, 2, 3, 2, 6, 1, 2, 1)));
    end

    // Called at a negedge; returns at the next negedge with the edge's effect visible.
    task automatic step(input bit t);
        pix_tick = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hsLowClk, vidOffTicks, lineTicks, hsMin, hsMax, bad, fires, ftCount;
        int ftFirst, ftSecond;
        outs_t held;

        #1 reset = 1'b1;
        step(0);
        step(0);
        report("reset state A", 64'(actA()), 64'(RESET_OUTS));
        report("reset state B", 64'(actB()), 64'(RESET_OUTS));
        reset = 1'b0;

        // One default line at one tick per four clocks.
        hsLowClk = 0; vidOffTicks = 0; lineTicks = 0; hsMin = 1023; hsMax = 0;
        for (int i = 0; i < 3200; i++) begin
            step(i % 4 == 0);
            if (i == 0) begin
                report("first tick col", 64'(aCol), 64'd0);
                report("first tick row", 64'(aRow), 64'd0);
                report("first tick video_on", 64'(aVon), 64'd1);
            end
            if (!aHs) hsLowClk++;
            if (aLt) lineTicks++;
            if (i % 4 == 0) begin
                if (!aVon) vidOffTicks++;
                if (!aHs) begin
                    if (aCol < hsMin) hsMin = aCol;
                    if (aCol > hsMax) hsMax = aCol;
                end
            end
        end
        report("hsync low clocks", 64'(hsLowClk), 64'd384);
        report("hsync first col", 64'(hsMin), 64'd656);
        report("hsync last col", 64'(hsMax), 64'd751);
        report("video_off ticks per line", 64'(vidOffTicks), 64'd160);
        report("line_tick per line", 64'(lineTicks), 64'd1);

        // Advance to col 700, row 1, then stall.
        for (int i = 0; i < 2804; i++) step(i % 4 == 0);
        report("pre-hold col", 64'(aCol), 64'd700);
        report("pre-hold row", 64'(aRow), 64'd1);
        held = actA();
        bad = 0; fires = 0;
        for (int i = 0; i < 1000; i++) begin
            step(0);
            if (actA() != held) bad++;
            if (aLt || aFt || bLt || bFt) fires++;
        end
        report("hold outputs stable", 64'(bad), 64'd0);
        report("hold no ticks", 64'(fires), 64'd0);

        // Asynchronous reset mid-run.
        step(1);
        reset = 1'b1;
        #1;
        report("async reset A", 64'(actA()), 64'(RESET_OUTS));
        @(negedge clk);
        step(0);
        reset = 1'b0;

        // pix_tick tied high on the small raster: 150 pixels per frame.
        ftCount = 0; ftFirst = -1; ftSecond = -1; bad = 0;
        for (int i = 0; i < 320; i++) begin
            step(1);
            if (bFt) begin
                ftCount++;
                if (!bLt) bad++;
                if (ftFirst < 0) ftFirst = i;
                else if (ftSecond < 0) ftSecond = i;
            end
        end
        report("frame_tick count", 64'(ftCount), 64'd2);
        report("frame_tick first", 64'(ftFirst), 64'd149);
        report("frame_tick period", 64'(ftSecond - ftFirst), 64'd150);
        report("frame_tick with line_tick", 64'(bad), 64'd0);

        // Same raster at one tick per four clocks.
        ftFirst = -1; ftSecond = -1;
        for (int i = 0; i < 1300; i++) begin
            step(i % 4 == 0);
            if (bFt) begin
                if (ftFirst < 0) ftFirst = i;
                else if (ftSecond < 0) ftSecond = i;
            end
        end
        report("frame_tick period 1-in-4", 64'(ftSecond - ftFirst), 64'd600);

        // Reset on the edge that would wrap the whole raster.
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        for (int i = 0; i < 149; i++) step(1);
        report("pre-wrap col B", 64'(bCol), 64'd13);
        report("pre-wrap row B", 64'(bRow), 64'd9);
        reset = 1'b1;
        #1;
        report("reset at wrap B", 64'(actB()), 64'(RESET_OUTS));
        @(negedge clk);
        fires = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (bFt || bLt) fires++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0);
            if (bFt || bLt) fires++;
        end
        report("no frame_tick around reset", 64'(fires), 64'd0);
        step(1);
        report("restart B col/row/video_on", 64'({bCol, bRow, bVon}), 64'({10'd0, 10'd0, 1'b1}));
        step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
